// File: rtl/hs_toggle_rx.sv
// hs_toggle_rx: responder end of a two-phase toggle req/ack handshake.
// Synchronizes req_tgl, captures req_data, presents it valid/ready, acks by toggle.
//
// Ports:
//   clk        receiving-domain clock
//   rst_n      asynchronous active-low reset
//   req_tgl    request toggle from the initiator (foreign domain)
//   req_data   request payload, held stable by the initiator until ack
//   ack_tgl    acknowledge toggle, driven straight from a flop
//   out_valid  captured payload available
//   out_data   captured payload, stable while out_valid
//   out_ready  consumer accepts on out_valid && out_ready
//   err_proto  sticky: initiator toggled again before seeing its ack
//   xfer_cnt   completed transfers, wraps
`timescale 1ns/1ps

module hs_toggle_rx #(
    parameter int DW          = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_tgl,
    input  logic [DW-1:0]    req_data,
    output logic             ack_tgl,
    output logic             out_valid,
    output logic [DW-1:0]    out_data,
    input  logic             out_ready,
    output logic             err_proto,
    output logic [CNT_W-1:0] xfer_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;
    logic                   req_d;
    logic                   req_edge;

    logic [DW-1:0]    data_q;
    logic [DW-1:0]    data_d;
    logic             valid_q;
    logic             valid_d;
    logic             ack_q;
    logic             ack_d;
    logic             err_q;
    logic             err_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Bit 0 is the metastable capture flop; the last stage is req_s.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            req_d  <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_tgl};
            req_d  <= req_s;
        end
    end

    assign req_s    = sync_q[SYNC_STAGES-1];
    assign req_edge = req_s ^ req_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // An edge seen in VALID is never queued: it only raises err_proto,
    // even when the same edge coincides with the acceptance, since the
    // initiator cannot yet have observed the ack it is answering.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        ack_d   = ack_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_edge) begin
                    data_d  = req_data;
                    valid_d = 1'b1;
                    state_d = VALID;
                end
            end
            VALID: begin
                if (req_edge) begin
                    err_d = 1'b1;
                end
                if (out_ready) begin
                    valid_d = 1'b0;
                    ack_d   = ~ack_q;
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ack_tgl   = ack_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign err_proto = err_q;
    assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_hs_toggle_rx.sv
// tb_hs_toggle_rx: self-checking bench for hs_toggle_rx.
// Scoreboard of expected payloads popped at each accepted output.
`timescale 1ns/1ps

module tb_hs_toggle_rx;

    localparam int DW    = 8;
    localparam int SS    = 2;
    localparam int CNT_W = 4;

    logic             clk;
    logic             clk_i;
    logic             rst_n;
    logic             req_tgl;
    logic [DW-1:0]    req_data;
    logic             ack_tgl;
    logic             out_valid;
    logic [DW-1:0]    out_data;
    logic             out_ready;
    logic             err_proto;
    logic [CNT_W-1:0] xfer_cnt;

    logic             ack_s1;
    logic             ack_s2;
    logic [DW-1:0]    exp_q[$];
    logic [DW-1:0]    exp_d;

    int n_cmp = 0;
    int n_bad = 0;

    hs_toggle_rx #(
        .DW(DW),
        .SYNC_STAGES(SS),
        .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .req_tgl(req_tgl),
        .req_data(req_data),
        .ack_tgl(ack_tgl),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_ready(out_ready),
        .err_proto(err_proto),
        .xfer_cnt(xfer_cnt)
    );

    // Local clock and an unrelated initiator clock, ratio 3:7.
    initial clk = 1'b0;
    always #15 clk = ~clk;
    initial clk_i = 1'b0;
    always #35 clk_i = ~clk_i;

    // Initiator-side two-flop synchronizer of ack_tgl.
    always @(posedge clk_i) begin
        ack_s1 <= ack_tgl;
        ack_s2 <= ack_s1;
    end

    // Scoreboard: inputs only change at negedge, so +2 ns is stable.
    always @(negedge clk) begin
        #2;
        if (rst_n && out_valid && out_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL sb_unexpected: out_data=%h, none expected",
                         out_data);
            end else begin
                exp_d = exp_q.pop_front();
                if (out_data !== exp_d) begin
                    n_bad++;
                    $display("FAIL sb_data: got %h want %h",
                             out_data, exp_d);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        req_tgl   = 1'b0;
        out_ready = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_flags: v=%b a=%b e=%b want 0 0 0",
                     out_valid, ack_tgl, err_proto);
        end
        n_cmp++;
        if (out_data !== 8'h00 || xfer_cnt !== 4'd0) begin
            n_bad++;
            $display("FAIL rst_regs: data=%h cnt=%0d want 00 0",
                     out_data, xfer_cnt);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_idle: v=%b a=%b want 0 0",
                     out_valid, ack_tgl);
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        out_ready = 1'b1;
        req_data  = 8'hA5;
        req_tgl   = ~req_tgl;
        exp_q.push_back(8'hA5);
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_early: valid=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack_tgl !== 1'b0) begin
            n_bad++;
            $display("FAIL single_valid: v=%b d=%h a=%b want 1 a5 0",
                     out_valid, out_data, ack_tgl);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || xfer_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL single_ack: v=%b a=%b cnt=%0d want 0 1 1",
                     out_valid, ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_backpressure();
        int bad_hold;
        @(negedge clk);
        out_ready = 1'b0;
        req_data  = 8'hA5;
        req_tgl   = ~req_tgl;
        exp_q.push_back(8'hA5);
        repeat (3) tick();
        bad_hold = 0;
        for (int i = 0; i < 10; i++) begin
            if (out_valid !== 1'b1 || out_data !== 8'hA5 || ack_tgl !== 1'b1)
                bad_hold++;
            tick();
        end
        n_cmp++;
        if (bad_hold != 0) begin
            n_bad++;
            $display("FAIL bp_hold: %0d bad cycles want 0 (v=%b d=%h a=%b)",
                     bad_hold, out_valid, out_data, ack_tgl);
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || xfer_cnt !== 4'd2) begin
            n_bad++;
            $display("FAIL bp_release: v=%b a=%b cnt=%0d want 0 0 2",
                     out_valid, ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic last;
        int   waited;
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        repeat (3) @(posedge clk_i);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clk_i);
            #1;
            last     = ack_s2;
            req_data = DW'(i);
            req_tgl  = ~req_tgl;
            exp_q.push_back(DW'(i));
            waited = 0;
            while (ack_s2 === last && waited < 100) begin
                @(posedge clk_i);
                #1;
                waited++;
            end
            n_cmp++;
            if (ack_s2 === last) begin
                n_bad++;
                $display("FAIL b2b_timeout: xfer %0d ack=%b never toggled",
                         i, ack_s2);
            end
        end
        repeat (10) tick();
        n_cmp++;
        if (ack_tgl !== 1'b0 || xfer_cnt !== 4'd4 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL b2b_final: a=%b cnt=%0d e=%b want 0 4 0",
                     ack_tgl, xfer_cnt, err_proto);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL b2b_drain: %0d left want 0", exp_q.size());
        end
    endtask

    task automatic test_violation();
        @(negedge clk);
        out_ready = 1'b0;
        req_data  = 8'h5A;
        req_tgl   = ~req_tgl;
        exp_q.push_back(8'h5A);
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b1 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL viol_first: v=%b e=%b want 1 0",
                     out_valid, err_proto);
        end
        repeat (3) tick();
        @(negedge clk);
        req_data = 8'hC3;
        req_tgl  = ~req_tgl;
        repeat (4) tick();
        n_cmp++;
        if (err_proto !== 1'b1 || out_data !== 8'h5A || ack_tgl !== 1'b0) begin
            n_bad++;
            $display("FAIL viol_err: e=%b d=%h a=%b want 1 5a 0",
                     err_proto, out_data, ack_tgl);
        end
        @(negedge clk);
        out_ready = 1'b1;
        tick();
        repeat (8) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || xfer_cnt !== 4'd5 ||
            err_proto !== 1'b1) begin
            n_bad++;
            $display("FAIL viol_after: v=%b a=%b cnt=%0d e=%b want 0 1 5 1",
                     out_valid, ack_tgl, xfer_cnt, err_proto);
        end
    endtask

    task automatic test_reset_in_valid();
        do_reset();
        @(negedge clk);
        out_ready = 1'b0;
        req_data  = 8'h96;
        req_tgl   = 1'b1;
        exp_q.push_back(8'h96);
        repeat (3) tick();
        n_cmp++;
        if (out_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL rv_pre: valid=%b want 1", out_valid);
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b0 || out_data !== 8'h00 ||
            xfer_cnt !== 4'd0 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL rv_async: v=%b a=%b d=%h cnt=%0d e=%b want all 0",
                     out_valid, ack_tgl, out_data, xfer_cnt, err_proto);
        end
        exp_q.delete();
        exp_q.push_back(8'h96);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        tick();
        tick();
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rv_early: valid=%b want 0", out_valid);
        end
        tick();
        n_cmp++;
        if (out_valid !== 1'b1 || out_data !== 8'h96) begin
            n_bad++;
            $display("FAIL rv_refill: v=%b d=%h want 1 96",
                     out_valid, out_data);
        end
        @(negedge clk);
        out_ready = 1'b1;
        repeat (10) tick();
        n_cmp++;
        if (out_valid !== 1'b0 || ack_tgl !== 1'b1 || xfer_cnt !== 4'd1) begin
            n_bad++;
            $display("FAIL rv_once: v=%b a=%b cnt=%0d want 0 1 1",
                     out_valid, ack_tgl, xfer_cnt);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            req_data = DW'($urandom_range(0, 255));
            req_tgl  = ~req_tgl;
            exp_q.push_back(req_data);
            repeat (5) tick();
        end
        n_cmp++;
        if (xfer_cnt !== 4'd1 || ack_tgl !== 1'b1 || err_proto !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_cnt: cnt=%0d a=%b e=%b want 1 1 0",
                     xfer_cnt, ack_tgl, err_proto);
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL wrap_drain: %0d left want 0", exp_q.size());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: sim time exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_tgl   = 1'b0;
        req_data  = '0;
        out_ready = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_violation();
        test_reset_in_valid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/hs_toggle_rx.md
# hs_toggle_rx

Receiving (responder) end of a two-phase toggle request/acknowledge handshake with a data bus. An initiator in a foreign clock domain drives `req_data`, then toggles `req_tgl`. This block synchronizes the toggle into `clk`, captures the data, and presents it on a valid/ready port. It returns completion by toggling `ack_tgl` once the local consumer accepts. It is the multi-bit, flow-controlled counterpart to the single-bit pulse synchronizers in the CDC library.

## Interface
- `DW`, 8, width of `req_data` / `out_data`
- `SYNC_STAGES`, 2, flops in the `req_tgl` synchronizer chain; legal values 2..4
- `CNT_W`, 16, width of the transfer counter
- `clk` input 1: receiving-domain clock
- `rst_n` input 1: reset. Asynchronous, active-low; one clock, all state in the `clk` domain.
- `req_tgl` input 1: request toggle from initiator (asynchronous to `clk`)
- `req_data` input DW: request payload. The initiator holds it stable from its `req_tgl` toggle until it observes `ack_tgl` toggle.
- `ack_tgl` output 1: acknowledge toggle back to initiator, driven directly from a flop
- `out_valid` output 1: captured payload available
- `out_data` output DW: captured payload, stable while `out_valid`=1
- `out_ready` input 1: consumer accepts when `out_valid`&&`out_ready` at a `clk` edge
- `err_proto` output 1: sticky protocol-violation flag
- `xfer_cnt` output CNT_W: completed transfers, wraps modulo 2^CNT_W

## Operation
- Synchronizer: `req_tgl` shifts through SYNC_STAGES flops each `clk`. Its last stage is `req_s`.
- Edge history: `req_d` is `req_s` registered one cycle later. `req_edge` = `req_s` ^ `req_d` (combinational).
- FSM states: IDLE, VALID.
  - IDLE, `req_edge`=1: capture `req_data` into `out_data`, set `out_valid`, go to VALID.
  - IDLE, `req_edge`=0: hold.
  - VALID, `out_ready`=1: clear `out_valid`, invert `ack_tgl`, increment `xfer_cnt`, go to IDLE.
  - VALID, `out_ready`=0: hold. `out_data` and `ack_tgl` are unchanged.
- `req_edge`=1 while in VALID (the initiator toggled before its ack): set `err_proto`. The edge is otherwise dropped, with no second capture and no extra ack. `err_proto` clears only on reset.
- Acceptance and the next edge in the same cycle: the acceptance completes and the FSM returns to IDLE. The edge is treated as a violation (`err_proto`=1), because the initiator cannot have seen the new ack yet.
- `req_data` is captured unsynchronized. This is legal because the protocol holds it stable for at least SYNC_STAGES+1 `clk` edges before `req_edge` asserts.
- Reset values, applied asynchronously on `rst_n`=0:
  - all synchronizer flops and `req_d`: 0
  - `ack_tgl`, `out_valid`, `err_proto`: 0
  - `out_data`, `xfer_cnt`: all zeros
  - FSM state: IDLE
- Reset mid-transfer abandons the transfer. `out_valid` drops immediately and `ack_tgl` does not toggle. If `req_tgl`=1 at reset release, the chain fills with 1 while `req_d`=0. This produces exactly one transfer, and is the defined behaviour.

## Timing
- Request latency: `req_tgl` stable before clk edge 0 → `req_s` changes after edge SYNC_STAGES-1. `out_valid`=1 after edge SYNC_STAGES, i.e. SYNC_STAGES+1 edges. Metastability resolution may add one cycle.
- Accept → ack: `out_valid`&&`out_ready` sampled at edge N → `ack_tgl` inverted and `out_valid`=0 after edge N.
- `xfer_cnt` updates on the same edge as `ack_tgl`.
- Minimum `out_valid` pulse: 1 cycle, when `out_ready` is already high.
- No combinational path from any input to any output.

## Test plan
- Single transfer, SYNC_STAGES=2, `out_ready`=1: `req_data`=8'hA5, `req_tgl` 0→1 → `out_valid` high for exactly 1 cycle, 3 edges after the toggle, with `out_data`=8'hA5. `ack_tgl` 0→1 on that same edge; `xfer_cnt`=1.
- Backpressure: same stimulus with `out_ready`=0 for 10 cycles → `out_valid`=1 and `out_data`=8'hA5 held, `ack_tgl`=0. Raise `out_ready` → one cycle later `out_valid`=0, `ack_tgl`=1.
- Back-to-back: initiator model on an unrelated clock (ratio 3:7) sends 8'h01..8'h04, waiting on its own 2-flop sync of `ack_tgl` → four outputs in order. Final `ack_tgl`=0, `xfer_cnt`=4, `err_proto`=0.
- Protocol violation: toggle `req_tgl` twice, 6 cycles apart, with `out_ready`=0 → `err_proto`=1 and stays 1. Only one capture (the first data); after accept, `ack_tgl` toggles once.
- Reset in VALID: assert `rst_n` while `out_valid`=1, `req_tgl`=1 → all outputs 0 immediately. After release, exactly one transfer occurs SYNC_STAGES+1 edges later, then none.
- Counter wrap, CNT_W=4: 17 completed transfers → `xfer_cnt`=4'd1.
